// File: rtl/ad100_pkg.sv
// rtl/ad100_pkg.sv - shared ad100 core types and constants
package ad100_pkg;

  localparam int XLEN = 32;

  // Word address of a 32-bit instruction: byte PC[31:2]
  typedef logic [XLEN-3:0] word_addr_t;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic {
    ST_RESET = 1'b0,
    ST_RUN   = 1'b1
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_to_pc(input word_addr_t w);
    return {w, 2'b00};
  endfunction

endpackage

// File: rtl/ad100_fetch_queue.sv
// rtl/ad100_fetch_queue.sv - prefetch FIFO of {pc, inst} with flush
module ad100_fetch_queue
  import ad100_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  word_addr_t       i_push_pc,
  input  logic [XLEN-1:0]  i_push_inst,
  input  logic             i_pop,
  output logic [CNT_W-1:0] o_count,
  output word_addr_t       o_head_pc,
  output logic [XLEN-1:0]  o_head_inst
);

  word_addr_t             r_pc_mem   [DEPTH];
  logic [XLEN-1:0]        r_inst_mem [DEPTH];
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [CNT_W-1:0]       r_count;
  logic                   w_pop;

  // Popping an empty queue is ignored so a stray ready cannot underflow
  assign w_pop       = i_pop && (r_count != '0);
  assign o_count     = r_count;
  assign o_head_pc   = r_pc_mem[r_rd_ptr];
  assign o_head_inst = r_inst_mem[r_rd_ptr];

  // Storage, pointers and occupancy; flush wins over push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]   <= '0;
        r_inst_mem[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_pc_mem[r_wr_ptr]   <= i_push_pc;
        r_inst_mem[r_wr_ptr] <= i_push_inst;
        r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ad100_fetch.sv
// rtl/ad100_fetch.sv - ad100 instruction fetch stage with prefetch queue
module ad100_fetch
  import ad100_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_rd,
  output logic [29:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int         CNT_W      = $clog2(DEPTH) + 1;
  localparam word_addr_t RESET_WORD = RESET_PC[31:2];

  fetch_state_t     r_state;
  fetch_state_t     w_state_nxt;
  word_addr_t       r_fetch_pc;
  word_addr_t       r_issue_pc;
  logic             r_inflight;
  logic             r_kill;
  logic             w_run;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W:0]   w_occ;
  word_addr_t       w_head_pc;
  logic [31:0]      w_head_inst;
  logic             w_unused_low;

  // Byte-offset bits of a redirect target carry no information
  assign w_unused_low = ^redirect_pc[1:0];

  // Occupancy counted against the queue uses the pre-pop count
  assign w_occ = {1'b0, w_count} + (CNT_W + 1)'(r_inflight);

  // State register for the reset/run sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and issue decision; reads never start in the reset state
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      ST_RESET: w_state_nxt = ST_RUN;
      ST_RUN:   w_run       = 1'b1;
      default:  w_state_nxt = ST_RESET;
    endcase
    w_issue = w_run && !redirect_valid && (w_occ < (CNT_W + 1)'(DEPTH));
  end

  // Program counter, in-flight tracking and the kill flag for redirects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_WORD;
      r_issue_pc <= RESET_WORD;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_kill     <= redirect_valid;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc[31:2];
      end else if (w_issue) begin
        r_issue_pc <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 30'd1;
      end
    end
  end

  assign w_push     = r_inflight && !r_kill;
  assign w_pop      = inst_valid && inst_ready;

  assign mem_rd     = w_issue;
  assign mem_addr   = r_fetch_pc;
  assign inst_valid = (w_count != '0);
  assign inst       = w_head_inst;
  assign inst_pc    = word_to_pc(w_head_pc);

  ad100_fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (redirect_valid),
    .i_push      (w_push),
    .i_push_pc   (r_issue_pc),
    .i_push_inst (mem_rdata),
    .i_pop       (w_pop),
    .o_count     (w_count),
    .o_head_pc   (w_head_pc),
    .o_head_inst (w_head_inst)
  );

endmodule
